// File: rtl/matrix_alu_seq_if.sv
// matrix_alu_seq_if
// Command/response bundle for the sequential matrix ALU.
//   cmd_valid/cmd_ready : command handshake (accepted when both high at a rising edge)
//   cmd_op/addr/data    : opcode, element index (row*N+col), write data
//   rsp_valid           : one-cycle completion pulse per accepted command
//   rsp_data/rsp_err    : read value / rejection flag, qualified by rsp_valid
//   busy                : operation in progress
interface matrix_alu_seq_if #(
  parameter int DATA_W = 32,
  parameter int N      = 3,
  parameter int AW     = $clog2(N*N)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq
// Sequential NxN matrix ALU. Holds operands E, F, result G and a determinant
// register; every command runs one element (or one product) per cycle.
//   i_clk   : rising-edge clock
//   i_reset : asynchronous active-high reset
//   bus     : command/response interface (slave side)
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// EXEC   | executing captured command, one step per cycle
// RESP   | rsp_valid pulse with rsp_data/rsp_err
module matrix_alu_seq #(
  parameter int DATA_W = 32,
  parameter int N      = 3,
  parameter int AW     = $clog2(N*N)
) (
  input  logic i_clk,
  input  logic i_reset,
  matrix_alu_seq_if.slave bus
);

  localparam int         NN   = N * N;
  localparam logic [1:0] LAST = 2'(N - 1);

  localparam logic [3:0] OP_WR_E   = 4'd0;
  localparam logic [3:0] OP_WR_F   = 4'd1;
  localparam logic [3:0] OP_RD_G   = 4'd2;
  localparam logic [3:0] OP_RD_DET = 4'd3;
  localparam logic [3:0] OP_TRN    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_MUL    = 4'd7;
  localparam logic [3:0] OP_DET    = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_e [NN];
  logic [DATA_W-1:0] r_f [NN];
  logic [DATA_W-1:0] r_g [NN];
  logic [DATA_W-1:0] r_det, r_acc, r_minor, r_rsp_data, r_wdata;
  logic [3:0]        r_op;
  logic [AW-1:0]     r_addr;
  logic              r_err;
  logic [1:0]        r_i, r_j, r_k;

  logic              w_accept, w_illegal, w_last;
  logic              w_ready, w_rsp_valid, w_busy;
  logic [DATA_W-1:0] w_pa, w_pb, w_prod, w_acc_mul, w_acc_det, w_term;
  logic [1:0]        w_ca, w_cb;

  function automatic logic [AW-1:0] idx(input logic [1:0] r, input logic [1:0] c);
    return AW'(int'(r) * N + int'(c));
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_RESP;
      end
      S_RESP: begin
        w_busy      = 1'b1;
        w_rsp_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept      = bus.cmd_valid && w_ready;
  assign bus.cmd_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.busy      = w_busy;
  assign bus.rsp_data  = w_rsp_valid ? r_rsp_data : '0;
  assign bus.rsp_err   = w_rsp_valid & r_err;

  // ---------------- decode ----------------
  always_comb begin
    w_illegal = 1'b0;
    case (bus.cmd_op)
      OP_WR_E, OP_WR_F, OP_RD_G: w_illegal = int'(bus.cmd_addr) >= NN;
      OP_RD_DET, OP_TRN, OP_ADD, OP_SUB, OP_MUL: w_illegal = 1'b0;
      OP_DET:  w_illegal = (N != 2) && (N != 3);
      default: w_illegal = 1'b1;
    endcase
  end

  // Final step of the captured command; rejected commands finish in one cycle.
  always_comb begin
    w_last = 1'b1;
    if (!r_err) begin
      case (r_op)
        OP_TRN, OP_ADD, OP_SUB: w_last = (r_i == LAST) && (r_j == LAST);
        OP_MUL: w_last = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);
        OP_DET: w_last = (N == 2) ? (r_k == 2'd1) : ((r_j == 2'd2) && (r_k == 2'd2));
        default: w_last = 1'b1;
      endcase
    end
  end

  // ---------------- shared multiplier ----------------
  // 3x3 determinant: for column j the minor uses the two other columns ca<cb
  // of rows 1 and 2. Phase k=0/1 builds the minor, k=2 scales it by E[0][j].
  assign w_ca = (r_j == 2'd0) ? 2'd1 : 2'd0;
  assign w_cb = (r_j == 2'd2) ? 2'd1 : 2'd2;

  always_comb begin
    w_pa = '0;
    w_pb = '0;
    if (r_op == OP_MUL) begin
      w_pa = r_e[idx(r_i, r_k)];
      w_pb = r_f[idx(r_k, r_j)];
    end else if (r_op == OP_DET) begin
      if (N == 2) begin
        w_pa = (r_k == 2'd0) ? r_e[idx(2'd0, 2'd0)] : r_e[idx(2'd0, 2'd1)];
        w_pb = (r_k == 2'd0) ? r_e[idx(2'd1, 2'd1)] : r_e[idx(2'd1, 2'd0)];
      end else begin
        case (r_k)
          2'd0: begin
            w_pa = r_e[idx(2'd1, w_ca)];
            w_pb = r_e[idx(2'd2, w_cb)];
          end
          2'd1: begin
            w_pa = r_e[idx(2'd1, w_cb)];
            w_pb = r_e[idx(2'd2, w_ca)];
          end
          default: begin
            w_pa = r_e[idx(2'd0, r_j)];
            w_pb = r_minor;
          end
        endcase
      end
    end
  end

  assign w_prod    = w_pa * w_pb;
  assign w_acc_mul = ((r_k == 2'd0) ? '0 : r_acc) + w_prod;
  assign w_term    = (r_j == 2'd1) ? -w_prod : w_prod;
  assign w_acc_det = ((r_j == 2'd0) ? '0 : r_acc) + w_term;

  // ---------------- datapath ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 0; n < NN; n++) begin
        r_e[n] <= '0;
        r_f[n] <= '0;
        r_g[n] <= '0;
      end
      r_det      <= '0;
      r_acc      <= '0;
      r_minor    <= '0;
      r_rsp_data <= '0;
      r_wdata    <= '0;
      r_op       <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
    end else if (w_accept) begin
      r_op       <= bus.cmd_op;
      r_addr     <= bus.cmd_addr;
      r_wdata    <= bus.cmd_data;
      r_err      <= w_illegal;
      r_rsp_data <= '0;
      r_acc      <= '0;
      r_minor    <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
    end else if (r_state == S_EXEC && !r_err) begin
      case (r_op)
        OP_WR_E:   r_e[r_addr] <= r_wdata;
        OP_WR_F:   r_f[r_addr] <= r_wdata;
        OP_RD_G:   r_rsp_data  <= r_g[r_addr];
        OP_RD_DET: r_rsp_data  <= r_det;
        OP_TRN:    r_g[idx(r_i, r_j)] <= r_e[idx(r_j, r_i)];
        OP_ADD:    r_g[idx(r_i, r_j)] <= r_e[idx(r_i, r_j)] + r_f[idx(r_i, r_j)];
        OP_SUB:    r_g[idx(r_i, r_j)] <= r_e[idx(r_i, r_j)] - r_f[idx(r_i, r_j)];
        OP_MUL: begin
          r_acc <= w_acc_mul;
          if (r_k == LAST) r_g[idx(r_i, r_j)] <= w_acc_mul;
        end
        OP_DET: begin
          if (N == 2) begin
            if (r_k == 2'd0) r_acc <= w_prod;
            else             r_det <= r_acc - w_prod;
          end else begin
            case (r_k)
              2'd0:    r_minor <= w_prod;
              2'd1:    r_minor <= r_minor - w_prod;
              default: begin
                r_acc <= w_acc_det;
                if (r_j == 2'd2) r_det <= w_acc_det;
              end
            endcase
          end
        end
        default: ;
      endcase

      // Step counters: elementwise ops walk (i,j); MUL walks (i,j,k) with k
      // innermost; DET walks column j with phase k.
      case (r_op)
        OP_TRN, OP_ADD, OP_SUB: begin
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= r_i + 2'd1;
          end else begin
            r_j <= r_j + 2'd1;
          end
        end
        OP_MUL: begin
          if (r_k == LAST) begin
            r_k <= '0;
            if (r_j == LAST) begin
              r_j <= '0;
              r_i <= r_i + 2'd1;
            end else begin
              r_j <= r_j + 2'd1;
            end
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        OP_DET: begin
          if (r_k == 2'd2) begin
            r_k <= '0;
            r_j <= r_j + 2'd1;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
module tb_matrix_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_alu_seq_if #(.DATA_W(32), .N(3)) bus3 ();
  matrix_alu_seq_if #(.DATA_W(32), .N(4)) bus4 ();

  matrix_alu_seq #(.DATA_W(32), .N(3)) u_dut (.i_clk(clk), .i_reset(rst), .bus(bus3));
  matrix_alu_seq #(.DATA_W(32), .N(4)) u_dut4 (.i_clk(clk), .i_reset(rst), .bus(bus4));

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t m_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the N=3 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus3.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          m_x = q.pop_front();
          chk({m_x.name, "_data"}, bus3.rsp_data, m_x.d);
          chk({m_x.name, "_err"}, {31'd0, bus3.rsp_err}, {31'd0, m_x.e});
          chk({m_x.name, "_latency"}, cyc - m_x.acc, m_x.lat);
        end
      end else begin
        chk("idle_rsp_data_zero", bus3.rsp_data, 32'd0);
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input int addr,
                       input logic [31:0] data, input logic [31:0] exp_d,
                       input logic exp_e, input int lat, input bit track);
    int w = 0;
    @(negedge clk);
    while (!bus3.cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus3.cmd_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    bus3.cmd_valid = 1'b1;
    bus3.cmd_op    = op;
    bus3.cmd_addr  = 4'(addr);
    bus3.cmd_data  = data;
    if (track) q.push_back('{exp_d, exp_e, cyc + 1, lat, name});
    @(posedge clk);
    #1;
    bus3.cmd_valid = 1'b0;
  endtask

  task automatic wr_mat(input logic [3:0] op, input int m[9]);
    for (int n = 0; n < 9; n++) issue("wr", op, n, 32'(m[n]), 32'd0, 1'b0, 1, 1'b1);
  endtask

  task automatic do4(input string name, input logic [3:0] op, input logic exp_e, input int exp_lat);
    int w = 0;
    @(negedge clk);
    bus4.cmd_valid = 1'b1;
    bus4.cmd_op    = op;
    bus4.cmd_addr  = '0;
    bus4.cmd_data  = '0;
    @(posedge clk);
    #1;
    bus4.cmd_valid = 1'b0;
    @(negedge clk);
    while (!bus4.rsp_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_err"}, {31'd0, bus4.rsp_err}, {31'd0, exp_e});
    chk({name, "_data"}, bus4.rsp_data, 32'd0);
    chk({name, "_latency"}, w, exp_lat);
  endtask

  int m_seq[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m_rev[9]  = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int m_two[9]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
  int m_id[9]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int m_d6[9]   = '{2, 0, 1, 1, 3, 2, 1, 1, 2};
  int m_dn3[9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 9};

  initial begin
    bus3.cmd_valid = 1'b0; bus3.cmd_op = '0; bus3.cmd_addr = '0; bus3.cmd_data = '0;
    bus4.cmd_valid = 1'b0; bus4.cmd_op = '0; bus4.cmd_addr = '0; bus4.cmd_data = '0;
    #1;
    chk("reset_ready", {31'd0, bus3.cmd_ready}, 32'd1);
    chk("reset_busy", {31'd0, bus3.busy}, 32'd0);
    chk("reset_rsp_valid", {31'd0, bus3.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Populate state, then abort a MUL with reset.
    wr_mat(4'd0, m_d6);
    issue("det6", 4'd8, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_det6", 4'd3, 0, 0, 32'd6, 1'b0, 1, 1'b1);
    issue("trn_pre", 4'd4, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_trn_pre", 4'd2, 1, 0, 32'd1, 1'b0, 1, 1'b1);
    issue("mul_abort", 4'd7, 0, 0, 32'd0, 1'b0, 27, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, bus3.cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus3.busy}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, bus3.rsp_valid}, 32'd0);
    chk("midrst_rsp_err", {31'd0, bus3.rsp_err}, 32'd0);
    chk("midrst_rsp_data", bus3.rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue("rd_g4_after_rst", 4'd2, 4, 0, 32'd0, 1'b0, 1, 1'b1);
    issue("rd_det_after_rst", 4'd3, 0, 0, 32'd0, 1'b0, 1, 1'b1);
    issue("trn_zero_e", 4'd4, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_g5_zero_e", 4'd2, 5, 0, 32'd0, 1'b0, 1, 1'b1);

    // Transpose
    wr_mat(4'd0, m_seq);
    issue("trn", 4'd4, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_trn_g1", 4'd2, 1, 0, 32'd4, 1'b0, 1, 1'b1);
    issue("rd_trn_g5", 4'd2, 5, 0, 32'd8, 1'b0, 1, 1'b1);

    // Add / subtract
    wr_mat(4'd1, m_two);
    issue("add", 4'd5, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_add_g8", 4'd2, 8, 0, 32'd11, 1'b0, 1, 1'b1);
    issue("sub", 4'd6, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_sub_g0", 4'd2, 0, 0, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
    issue("rd_sub_g4", 4'd2, 4, 0, 32'd3, 1'b0, 1, 1'b1);

    // Multiply
    wr_mat(4'd1, m_id);
    issue("mul_id", 4'd7, 0, 0, 32'd0, 1'b0, 27, 1'b1);
    for (int n = 0; n < 9; n++) issue("rd_mul_id", 4'd2, n, 0, 32'(n + 1), 1'b0, 1, 1'b1);
    wr_mat(4'd1, m_rev);
    issue("mul_rev", 4'd7, 0, 0, 32'd0, 1'b0, 27, 1'b1);
    issue("rd_mul_g0", 4'd2, 0, 0, 32'd30, 1'b0, 1, 1'b1);
    issue("rd_mul_g1", 4'd2, 1, 0, 32'd24, 1'b0, 1, 1'b1);
    issue("rd_mul_g8", 4'd2, 8, 0, 32'd90, 1'b0, 1, 1'b1);

    // Determinant (G must survive)
    issue("det_seq", 4'd8, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_det_seq", 4'd3, 0, 0, 32'd0, 1'b0, 1, 1'b1);
    issue("rd_g0_after_det", 4'd2, 0, 0, 32'd30, 1'b0, 1, 1'b1);
    wr_mat(4'd0, m_d6);
    issue("det_d6", 4'd8, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_det_d6", 4'd3, 0, 0, 32'd6, 1'b0, 1, 1'b1);
    wr_mat(4'd0, m_dn3);
    issue("det_dn3", 4'd8, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_det_dn3", 4'd3, 0, 0, 32'hFFFF_FFFD, 1'b0, 1, 1'b1);
    issue("rd_g8_after_det", 4'd2, 8, 0, 32'd90, 1'b0, 1, 1'b1);

    // Wrap-around add
    issue("wr_e0_max", 4'd0, 0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1, 1'b1);
    issue("wr_f0_one", 4'd1, 0, 32'd1, 32'd0, 1'b0, 1, 1'b1);
    issue("add_wrap", 4'd5, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_add_wrap", 4'd2, 0, 0, 32'h8000_0000, 1'b0, 1, 1'b1);

    // Errors
    issue("op12", 4'd12, 0, 32'd5, 32'd0, 1'b1, 1, 1'b1);
    issue("wr_e_addr9", 4'd0, 9, 32'd55, 32'd0, 1'b1, 1, 1'b1);
    issue("wr_e_addr8_bad", 4'd0, 15, 32'd55, 32'd0, 1'b1, 1, 1'b1);
    issue("rd_g_addr9", 4'd2, 9, 0, 32'd0, 1'b1, 1, 1'b1);
    issue("trn_check_e", 4'd4, 0, 0, 32'd0, 1'b0, 9, 1'b1);
    issue("rd_e0_kept", 4'd2, 0, 0, 32'h7FFF_FFFF, 1'b0, 1, 1'b1);
    issue("rd_e8_kept", 4'd2, 8, 0, 32'd9, 1'b0, 1, 1'b1);

    // N=4 instance
    do4("n4_det", 4'd8, 1'b1, 1);
    do4("n4_add", 4'd5, 1'b0, 16);

    begin
      int w = 0;
      while (q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
